// File: rtl/rv32i_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM encoding
//   NOP_INSN    : instruction returned to IF when a fetch is aborted
package rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IF_ACC = 2'b01,
    DM_ACC = 2'b10,
    RESP   = 2'b11
  } arb_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

endpackage : rv32i_pkg

// File: rtl/mem_wait_timer.sv
// Watchdog counter for one bus access.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (has priority over enable)
//   enable     : count one more cycle without acknowledge
//   expired    : count has reached MAX_WAIT
// The count saturates at MAX_WAIT and never wraps.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign expired = (wait_cnt == CNT_W'(MAX_WAIT));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable && !expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule : mem_wait_timer

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between IF fetch and MEM load/store.
//   if_*    : fetch request (level) / instruction return with ready pulse
//   dm_*    : load/store request from mem_rd/mem_wr / load return with ready pulse
//   bus_*   : req/ack handshake towards the memory subsystem
//   stall_* : combinational pipeline freeze signals
//   err_out : one-cycle pulse on watchdog abort or rd&wr request
// Data requests always win over fetch. Each access is IDLE -> *_ACC -> RESP,
// so throughput is one access per three cycles at best.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_in,
  input  logic [ADDR_W-1:0]   if_addr_in,
  output logic [DATA_W-1:0]   if_rdata_out,
  output logic                if_ready_out,
  input  logic                dm_rd_in,
  input  logic                dm_wr_in,
  input  logic [ADDR_W-1:0]   dm_addr_in,
  input  logic [DATA_W-1:0]   dm_wdata_in,
  input  logic [DATA_W/8-1:0] dm_be_in,
  output logic [DATA_W-1:0]   dm_rdata_out,
  output logic                dm_ready_out,
  output logic                bus_req_out,
  output logic                bus_we_out,
  output logic [ADDR_W-1:0]   bus_addr_out,
  output logic [DATA_W-1:0]   bus_wdata_out,
  output logic [DATA_W/8-1:0] bus_be_out,
  input  logic                bus_ack_in,
  input  logic [DATA_W-1:0]   bus_rdata_in,
  output logic                stall_if_out,
  output logic                stall_mem_out,
  output logic                err_out
);

  arb_state_t state, state_nxt;
  logic       owner_dm;   // 1 = current access belongs to the data port
  logic       err_flag;   // abort or illegal rd&wr seen for current access
  logic       dm_req;
  logic       in_acc;
  logic       expired;
  logic       ack_ok;
  logic       abort;

  assign dm_req = dm_rd_in | dm_wr_in;
  assign in_acc = (state == IF_ACC) || (state == DM_ACC);
  // Once the watchdog fires the request is already withdrawn, so a late
  // acknowledge in that cycle is not accepted.
  assign abort  = in_acc & expired;
  assign ack_ok = in_acc & ~expired & bus_ack_in;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_acc),
    .enable  (in_acc),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:           if (dm_req)         state_nxt = DM_ACC;
                      else if (if_req_in) state_nxt = IF_ACC;
      IF_ACC, DM_ACC: if (ack_ok || abort) state_nxt = RESP;
      RESP:           state_nxt = IDLE;  // requests ignored: no double grant
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_dm      <= 1'b0;
      err_flag      <= 1'b0;
      bus_we_out    <= 1'b0;
      bus_addr_out  <= '0;
      bus_wdata_out <= '0;
      bus_be_out    <= '0;
      if_rdata_out  <= '0;
      dm_rdata_out  <= '0;
    end else begin
      if (state == IDLE) begin
        if (dm_req) begin
          // rd&wr together is performed as a write and flagged.
          owner_dm      <= 1'b1;
          err_flag      <= dm_rd_in & dm_wr_in;
          bus_we_out    <= dm_wr_in;
          bus_addr_out  <= dm_addr_in;
          bus_wdata_out <= dm_wdata_in;
          bus_be_out    <= dm_wr_in ? dm_be_in : '1;
        end else if (if_req_in) begin
          owner_dm     <= 1'b0;
          err_flag     <= 1'b0;
          bus_we_out   <= 1'b0;
          bus_addr_out <= if_addr_in;
          bus_be_out   <= '1;
        end
      end
      if (ack_ok) begin
        if (owner_dm) dm_rdata_out <= bus_rdata_in;
        else          if_rdata_out <= bus_rdata_in;
      end
      if (abort) begin
        err_flag <= 1'b1;
        if (owner_dm) dm_rdata_out <= '0;
        else          if_rdata_out <= DATA_W'(NOP_INSN);
      end
    end
  end

  assign bus_req_out   = in_acc & ~expired;
  assign if_ready_out  = (state == RESP) & ~owner_dm;
  assign dm_ready_out  = (state == RESP) &  owner_dm;
  assign err_out       = (state == RESP) &  err_flag;
  assign stall_mem_out = dm_req & ~dm_ready_out;
  assign stall_if_out  = stall_mem_out | (if_req_in & ~if_ready_out);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1 ns after the rising
// edge; outputs are checked on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic [31:0] if_rdata_out;
  logic        if_ready_out;
  logic        dm_rd_in = 1'b0;
  logic        dm_wr_in = 1'b0;
  logic [31:0] dm_addr_in = '0;
  logic [31:0] dm_wdata_in = '0;
  logic [3:0]  dm_be_in = '0;
  logic [31:0] dm_rdata_out;
  logic        dm_ready_out;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [31:0] bus_wdata_out;
  logic [3:0]  bus_be_out;
  logic        bus_ack_in = 1'b0;
  logic [31:0] bus_rdata_in = '0;
  logic        stall_if_out;
  logic        stall_mem_out;
  logic        err_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_in     (if_req_in),
    .if_addr_in    (if_addr_in),
    .if_rdata_out  (if_rdata_out),
    .if_ready_out  (if_ready_out),
    .dm_rd_in      (dm_rd_in),
    .dm_wr_in      (dm_wr_in),
    .dm_addr_in    (dm_addr_in),
    .dm_wdata_in   (dm_wdata_in),
    .dm_be_in      (dm_be_in),
    .dm_rdata_out  (dm_rdata_out),
    .dm_ready_out  (dm_ready_out),
    .bus_req_out   (bus_req_out),
    .bus_we_out    (bus_we_out),
    .bus_addr_out  (bus_addr_out),
    .bus_wdata_out (bus_wdata_out),
    .bus_be_out    (bus_be_out),
    .bus_ack_in    (bus_ack_in),
    .bus_rdata_in  (bus_rdata_in),
    .stall_if_out  (stall_if_out),
    .stall_mem_out (stall_mem_out),
    .err_out       (err_out)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset state ----
    #12;
    check("rst bus_req",  32'(bus_req_out), 32'd0);
    check("rst if_ready", 32'(if_ready_out), 32'd0);
    check("rst dm_ready", 32'(dm_ready_out), 32'd0);
    check("rst err",      32'(err_out), 32'd0);
    check("rst if_rdata", if_rdata_out, 32'd0);
    check("rst dm_rdata", dm_rdata_out, 32'd0);
    check("rst bus_addr", bus_addr_out, 32'd0);
    check("rst stall_if", 32'(stall_if_out), 32'd0);
    tick();
    rst_n = 1'b1;

    // ---- 1: fetch only, ack in cycle 1 ----
    if_req_in = 1'b1; if_addr_in = 32'h100;                 // cycle 0
    mid();
    check("t1 c0 bus_req",  32'(bus_req_out), 32'd0);
    check("t1 c0 stall_if", 32'(stall_if_out), 32'd1);
    tick();                                                  // cycle 1
    bus_ack_in = 1'b1; bus_rdata_in = 32'h0050_0093;
    mid();
    check("t1 c1 bus_req",  32'(bus_req_out), 32'd1);
    check("t1 c1 bus_addr", bus_addr_out, 32'h100);
    check("t1 c1 bus_we",   32'(bus_we_out), 32'd0);
    check("t1 c1 bus_be",   32'(bus_be_out), 32'hF);
    tick();                                                  // cycle 2
    bus_ack_in = 1'b0; bus_rdata_in = '0;
    mid();
    check("t1 c2 if_ready", 32'(if_ready_out), 32'd1);
    check("t1 c2 if_rdata", if_rdata_out, 32'h0050_0093);
    check("t1 c2 stall_if", 32'(stall_if_out), 32'd0);
    check("t1 c2 bus_req",  32'(bus_req_out), 32'd0);
    check("t1 c2 err",      32'(err_out), 32'd0);
    tick();                                                  // cycle 3
    if_req_in = 1'b0;
    mid();
    check("t1 c3 if_ready", 32'(if_ready_out), 32'd0);
    check("t1 c3 bus_req",  32'(bus_req_out), 32'd0);
    check("t1 c3 if_rdata hold", if_rdata_out, 32'h0050_0093);

    // ---- 2: simultaneous fetch and load, data wins ----
    tick();                                                  // cycle 0
    if_req_in = 1'b1; if_addr_in = 32'h104;
    dm_rd_in = 1'b1;  dm_addr_in = 32'h2000;
    mid();
    check("t2 c0 stall_mem", 32'(stall_mem_out), 32'd1);
    check("t2 c0 stall_if",  32'(stall_if_out), 32'd1);
    tick();                                                  // cycle 1
    bus_ack_in = 1'b1; bus_rdata_in = 32'hDEAD_BEEF;
    mid();
    check("t2 c1 bus_req",  32'(bus_req_out), 32'd1);
    check("t2 c1 bus_addr", bus_addr_out, 32'h2000);
    check("t2 c1 bus_we",   32'(bus_we_out), 32'd0);
    tick();                                                  // cycle 2
    bus_ack_in = 1'b0; bus_rdata_in = '0;
    mid();
    check("t2 c2 dm_ready",  32'(dm_ready_out), 32'd1);
    check("t2 c2 dm_rdata",  dm_rdata_out, 32'hDEAD_BEEF);
    check("t2 c2 if_ready",  32'(if_ready_out), 32'd0);
    check("t2 c2 stall_mem", 32'(stall_mem_out), 32'd0);
    check("t2 c2 stall_if",  32'(stall_if_out), 32'd1);
    tick();                                                  // cycle 3: IDLE grants IF
    dm_rd_in = 1'b0;
    mid();
    check("t2 c3 bus_req",  32'(bus_req_out), 32'd0);
    tick();                                                  // cycle 4
    bus_ack_in = 1'b1; bus_rdata_in = 32'h1111_1111;
    mid();
    check("t2 c4 bus_req",  32'(bus_req_out), 32'd1);
    check("t2 c4 bus_addr", bus_addr_out, 32'h104);
    tick();                                                  // cycle 5
    bus_ack_in = 1'b0; bus_rdata_in = '0;
    mid();
    check("t2 c5 if_ready", 32'(if_ready_out), 32'd1);
    check("t2 c5 if_rdata", if_rdata_out, 32'h1111_1111);
    check("t2 c5 dm_rdata hold", dm_rdata_out, 32'hDEAD_BEEF);
    tick();
    if_req_in = 1'b0;

    // ---- 3: store, ack delayed 4 cycles, bus held stable ----
    tick();                                                  // cycle 0
    dm_wr_in = 1'b1; dm_addr_in = 32'h3000; dm_wdata_in = 32'h1234; dm_be_in = 4'b0011;
    for (int c = 1; c <= 4; c++) begin
      tick();
      dm_addr_in = 32'hFFFF_0000; dm_wdata_in = 32'h5555_5555; dm_be_in = 4'b1100;
      mid();
      check($sformatf("t3 c%0d bus_req", c),   32'(bus_req_out), 32'd1);
      check($sformatf("t3 c%0d bus_we", c),    32'(bus_we_out), 32'd1);
      check($sformatf("t3 c%0d bus_be", c),    32'(bus_be_out), 32'h3);
      check($sformatf("t3 c%0d bus_addr", c),  bus_addr_out, 32'h3000);
      check($sformatf("t3 c%0d bus_wdata", c), bus_wdata_out, 32'h1234);
      check($sformatf("t3 c%0d dm_ready", c),  32'(dm_ready_out), 32'd0);
    end
    tick();                                                  // cycle 5
    bus_ack_in = 1'b1;
    mid();
    check("t3 c5 bus_req", 32'(bus_req_out), 32'd1);
    tick();                                                  // cycle 6
    bus_ack_in = 1'b0;
    mid();
    check("t3 c6 dm_ready", 32'(dm_ready_out), 32'd1);
    check("t3 c6 err",      32'(err_out), 32'd0);
    tick();                                                  // cycle 7
    dm_wr_in = 1'b0;
    mid();
    check("t3 c7 dm_ready", 32'(dm_ready_out), 32'd0);

    // ---- 4: fetch never acknowledged, watchdog abort ----
    tick();                                                  // cycle 0
    if_req_in = 1'b1; if_addr_in = 32'h200;
    for (int c = 1; c <= 15; c++) begin
      tick();
      mid();
      check($sformatf("t4 c%0d bus_req", c), 32'(bus_req_out), 32'd1);
      check($sformatf("t4 c%0d if_ready", c), 32'(if_ready_out), 32'd0);
    end
    tick();                                                  // cycle 16: expired
    mid();
    check("t4 c16 bus_req",  32'(bus_req_out), 32'd0);
    check("t4 c16 if_ready", 32'(if_ready_out), 32'd0);
    tick();                                                  // cycle 17: RESP
    mid();
    check("t4 c17 if_ready", 32'(if_ready_out), 32'd1);
    check("t4 c17 err",      32'(err_out), 32'd1);
    check("t4 c17 if_rdata", if_rdata_out, 32'h0000_0013);
    tick();                                                  // cycle 18
    if_req_in = 1'b0;
    mid();
    check("t4 c18 err",      32'(err_out), 32'd0);

    // ---- 5: reset asserted mid-access ----
    tick();                                                  // cycle 0
    dm_rd_in = 1'b1; dm_addr_in = 32'h4000;
    tick();                                                  // cycle 1
    mid();
    check("t5 c1 bus_req", 32'(bus_req_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async bus_req",  32'(bus_req_out), 32'd0);
    check("t5 async dm_ready", 32'(dm_ready_out), 32'd0);
    dm_rd_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mid();
    check("t5 rel bus_req",  32'(bus_req_out), 32'd0);
    check("t5 rel dm_ready", 32'(dm_ready_out), 32'd0);
    check("t5 rel dm_rdata", dm_rdata_out, 32'd0);
    tick();
    mid();
    check("t5 idle bus_req", 32'(bus_req_out), 32'd0);
    check("t5 idle err",     32'(err_out), 32'd0);

    // ---- 6: rd & wr together -> write plus error ----
    tick();                                                  // cycle 0
    dm_rd_in = 1'b1; dm_wr_in = 1'b1;
    dm_addr_in = 32'h5000; dm_wdata_in = 32'hCAFE; dm_be_in = 4'b1111;
    tick();                                                  // cycle 1
    bus_ack_in = 1'b1;
    mid();
    check("t6 c1 bus_req",   32'(bus_req_out), 32'd1);
    check("t6 c1 bus_we",    32'(bus_we_out), 32'd1);
    check("t6 c1 bus_wdata", bus_wdata_out, 32'hCAFE);
    check("t6 c1 bus_addr",  bus_addr_out, 32'h5000);
    tick();                                                  // cycle 2
    bus_ack_in = 1'b0;
    mid();
    check("t6 c2 dm_ready", 32'(dm_ready_out), 32'd1);
    check("t6 c2 err",      32'(err_out), 32'd1);
    tick();                                                  // cycle 3
    dm_rd_in = 1'b0; dm_wr_in = 1'b0;
    mid();
    check("t6 c3 err",      32'(err_out), 32'd0);
    check("t6 c3 dm_ready", 32'(dm_ready_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
